mcycle_ctrl: RTL
================

Name: mcycle_ctrl

Overview:
- Sequencer and iterative datapath for RV32M multiply/divide in the EX stage.
- Accepts one operation from EX and runs a radix-2 shift-add/shift-subtract loop.
- Drives `Busy` into the hazard unit, which holds F/D for the whole operation; the top level also uses `Busy` to hold E and bubble M.
- Returns a WIDTH-bit result with a one-cycle `Done` strobe.

Parameters:
WIDTH, 32, operand/result width in bits (≥ 4, power of 2)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESETn  input  1  synchronous, active-low reset
Start  input  1  EX-stage instruction is an M-extension op (opcode 0110011, funct7 0000001)
MCycleOp  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Operand1  input  WIDTH  rs1 value (post-forwarding)
Operand2  input  WIDTH  rs2 value (post-forwarding)
Result  output  WIDTH  registered result; valid when Done=1, held until next completion
Busy  output  1  to hazard unit; high while operation in flight
Done  output  1  single-cycle completion strobe

Behaviour:
- Clock and reset: one clock `CLK`. Reset is synchronous and active-low (`RESETn`).
- Reset (`RESETn`=0 at an edge):
  - state = IDLE; `Result` = 0; `Done` = 0; counter and internal registers = 0.
  - `Busy` = 0 during reset and in the cycle after.
  - Reset mid-operation aborts it with no result.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - `Busy` = `Start` (combinational, same cycle, so the stall applies immediately).
  - On `Start`=1: latch op; latch |Operand1| and |Operand2| for signed variants (MULH: both signed; MULHSU: rs1 only; DIV/REM: both); latch the result-sign flag; count = WIDTH-1; go to COMPUTE.
- COMPUTE:
  - `Busy` = 1.
  - One iteration per cycle.
  - Multiply: 2W accumulator, add multiplicand if multiplier LSB is 1, then shift right.
  - Divide: restoring; shift remainder left by 1 with next dividend bit, subtract divisor, keep if non-negative, set quotient bit.
  - When count = 0: apply sign correction (two's-complement negate), select the low/high half or quotient/remainder, register `Result`, go to DONE.
  - Otherwise count decrements by 1.
- DONE:
  - `Busy` = 0 and `Done` = 1 for exactly one cycle; go to IDLE.
  - `Start` is ignored in DONE: it is the same instruction leaving E and must not relaunch.
- Latency: `Start` seen at cycle 0 gives `Busy` high cycles 0..WIDTH and `Done` plus valid `Result` at cycle WIDTH+1. Total WIDTH+2 cycles; WIDTH+1 stall cycles.
- Back-to-back ops: a second `Start` is accepted at the earliest in the IDLE cycle after DONE.
- Operand/op changes during COMPUTE are ignored; everything is latched at launch.
- Divide by zero (no trap):
  - DIV/DIVU quotient = all ones.
  - REM/REMU = Operand1.
  - Full WIDTH iterations still run, so latency is unchanged.
- Signed overflow (DIV of −2^(WIDTH−1) by −1): quotient = −2^(WIDTH−1); REM = 0.
- Remainder sign follows the dividend; quotient sign = XOR of operand signs, except the divide-by-zero case above.
- MUL returns the low WIDTH bits regardless of signedness; MULH* return the high WIDTH bits of the correctly signed 2W product.
- `Busy` and `Done` are never high in the same cycle.
- `Busy` never stays high for more than WIDTH+1 consecutive cycles.

Test Plan:
- Reset then MUL 7 × −3 (0x00000007, 0xFFFFFFFD):
  - `Busy` high cycles 0..32.
  - `Done` at cycle 33 with `Result` = 0xFFFFFFEB.
  - `Busy` = 0 at cycle 33.
- MULH 0x80000000 × 0x80000000 → `Result` 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide:
  - DIV −7 / 2 → 0xFFFFFFFD; REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- Edge cases:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All with 33-cycle `Busy`.
- Back-to-back and held `Start`:
  - `Start` held high through DONE produces exactly one `Done`.
  - `Start` reasserted the cycle after DONE launches a second op.
  - Operands changed mid-COMPUTE do not alter `Result`.
- Reset mid-operation:
  - `RESETn` low at cycle 10 of a DIV: `Busy` low the next cycle, no `Done`, `Result` = 0.
  - A subsequent op completes correctly.

Source files
------------

// File: rtl/mcycle_ctrl_if.sv
// EX-stage <-> multiply/divide unit port bundle.
// The EX stage is the master; mcycle_ctrl is the slave.
interface mcycle_ctrl_if #(
  parameter int WIDTH = 32
);
  // Start is a request level, not a pulse: the op is taken in the IDLE cycle
  // where Start=1, Busy rises combinationally that same cycle and stays high
  // until the result registers. Done pulses for one cycle with Result valid.
  // Result then holds until the next completion. Start is ignored while
  // Busy or Done is high.
  logic             Start;
  logic [2:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result, Busy, Done
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide on a shared 2W accumulator, one iteration per clock.
module mcycle_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RESETn,
  mcycle_ctrl_if.slave bus,
  output logic [1:0]   fsm_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;

  // Launch-time operand conditioning
  logic             s1, s2;
  logic             signed1, signed2;
  logic [WIDTH-1:0] abs1, abs2;
  logic             neg_launch;

  always_comb begin
    s1      = bus.Operand1[WIDTH-1];
    s2      = bus.Operand2[WIDTH-1];
    signed1 = (bus.MCycleOp == 3'b001) || (bus.MCycleOp == 3'b010) ||
              (bus.MCycleOp == 3'b100) || (bus.MCycleOp == 3'b110);
    signed2 = (bus.MCycleOp == 3'b001) || (bus.MCycleOp == 3'b100) ||
              (bus.MCycleOp == 3'b110);
    abs1    = (signed1 && s1) ? -bus.Operand1 : bus.Operand1;
    abs2    = (signed2 && s2) ? -bus.Operand2 : bus.Operand2;
    // Quotient of x/0 is all ones, so its sign correction is suppressed.
    case (bus.MCycleOp)
      3'b001:  neg_launch = s1 ^ s2;
      3'b010:  neg_launch = s1;
      3'b100:  neg_launch = (s1 ^ s2) & (|bus.Operand2);
      3'b110:  neg_launch = s1;
      default: neg_launch = 1'b0;
    endcase
  end

  // One iteration of either datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = shifted - {1'b0, mcand_q};
    // A failed subtract means shifted < divisor, so its top bit is zero.
    if (trial[WIDTH])
      div_next = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_next = op_q[2] ? div_next : mul_next;
  end

  // Sign correction and half/quotient/remainder selection on the final step
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_sel;
  logic [WIDTH-1:0]   div_res;
  logic [WIDTH-1:0]   final_res;

  always_comb begin
    prod    = neg_q ? -acc_next : acc_next;
    div_sel = op_q[1] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    div_res = neg_q ? -div_sel : div_sel;
    if (op_q[2])
      final_res = div_res;
    else if (op_q[1:0] == 2'b00)
      final_res = prod[WIDTH-1:0];
    else
      final_res = prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state    <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            op_q    <= bus.MCycleOp;
            neg_q   <= neg_launch;
            count_q <= CW'(WIDTH - 1);
            if (bus.MCycleOp[2]) begin
              mcand_q <= abs2;
              acc_q   <= {{WIDTH{1'b0}}, abs1};
            end else begin
              mcand_q <= abs1;
              acc_q   <= {{WIDTH{1'b0}}, abs2};
            end
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc_q <= acc_next;
          if (count_q == '0) begin
            result_q <= final_res;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        DONE: begin
          // Start may still be high from the instruction now leaving E.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy   = (state == COMPUTE) || ((state == IDLE) && bus.Start && RESETn);
  assign bus.Done   = done_q;
  assign bus.Result = result_q;
  assign fsm_state  = state;
endmodule
